// File: rtl/lsu_mem_master.sv
// Load/store master: turns EXU requests into one word-aligned pmem access, extends load data.
// Latency from acceptance: error 1 cycle, store 2 cycles, load 2+MEM_LAT cycles to resp_valid.
// Backpressure: one transaction in flight; req_ready only in IDLE, RESP holds until resp_ready.
module lsu_mem_master #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;

  logic        req_bad;
  logic [3:0]  base;
  logic [3:0]  lane_mask;
  logic [31:0] sh;
  logic [31:0] load_ext;

  // Request legality and store lane mask, decoded straight from the incoming request.
  always_comb begin
    req_bad = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    case (req_size)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    lane_mask = base << req_addr[1:0];
  end

  // Load data: shift the addressed lane down, then sign/zero extend by size.
  always_comb begin
    sh = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = sext_q ? {{24{sh[7]}}, sh[7:0]}   : {24'b0, sh[7:0]};
      2'b01:   load_ext = sext_q ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: load_ext = sh;
    endcase
  end

  // Next-state logic; memory outputs are computed one cycle ahead so they come out of flops in REQ.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    off_d       = off_q;
    size_d      = size_q;
    sext_d      = sext_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_valid_d = 1'b0;
    mem_wen_d   = 1'b0;
    mem_wdata_d = 32'h0;
    mem_wmask_d = 8'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          off_d   = req_addr[1:0];
          size_d  = req_size;
          sext_d  = req_sext;
          rdata_d = 32'h0;
          err_d   = req_bad;
          if (req_bad) begin
            state_d = RESP;
          end else begin
            state_d     = REQ;
            mem_valid_d = 1'b1;
            mem_wen_d   = req_wen;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            if (req_wen) begin
              mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
              mem_wmask_d = {4'b0000, lane_mask};
            end
          end
        end
      end
      REQ: begin
        if (wen_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = load_ext;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // State, latched request fields and registered outputs; reset clears everything but req_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      wen_q        <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wmask_q  <= 8'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = mem_valid_q;
  assign mem_wen    = mem_wen_q;
  assign mem_raddr  = mem_addr_q;
  assign mem_waddr  = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: one instance at MEM_LAT=1, one at MEM_LAT=3 for the reset case.
// Both share request stimulus and a simple registered memory model.
// Responses are always accepted except during the backpressure case.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic        req_valid, req_wen, req_sext, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [31:0] mem_rdata, mem_word;

  logic        req_ready, resp_valid, resp_err, mem_valid, mem_wen;
  logic [31:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;

  logic        req_ready3, resp_valid3, resp_err3, mem_valid3, mem_wen3;
  logic [31:0] resp_rdata3, mem_raddr3, mem_waddr3, mem_wdata3;
  logic [7:0]  mem_wmask3;

  int n_cmp = 0;
  int n_bad = 0;
  int mv_cnt = 0;
  int mv3_cnt = 0;
  int cyc;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  lsu_mem_master #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .req_valid(req_valid), .req_ready(req_ready3), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
    .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_valid(mem_valid3), .mem_raddr(mem_raddr3), .mem_rdata(mem_rdata), .mem_wen(mem_wen3),
    .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3), .mem_wmask(mem_wmask3)
  );

  // Memory model: a read registers the current memory word and holds it until the next read.
  always @(posedge clk) begin
    if ((mem_valid && !mem_wen) || (mem_valid3 && !mem_wen3)) mem_rdata <= mem_word;
    if (mem_valid) mv_cnt <= mv_cnt + 1;
    if (mem_valid3) mv3_cnt <= mv3_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; afterwards we are in the cycle following acceptance ("cycle 1").
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sext);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_sext  = sext;
    tick();
    req_valid = 1'b0;
  endtask

  // Count cycles until resp_valid (first cycle after acceptance is 1), bounded.
  task automatic wait_resp(output int n);
    n = 1;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    mem_rdata = 32'h0; mem_word = 32'h0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_sext = 1'b0; resp_ready = 1'b1;
    rst_n = 1'b1; rst3_n = 1'b1;
    #2;
    rst_n = 1'b0; rst3_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: word load
    mem_word = 32'hDEADBEEF;
    mv_cnt = 0;
    do_req(1'b0, 32'h80000004, 32'h0, 2'b10, 1'b0);
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    chk("t1_raddr", mem_raddr, 32'h80000004);
    chk("t1_mem_wen", 32'(mem_wen), 32'd0);
    wait_resp(cyc);
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_rdata", resp_rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(resp_err), 32'd0);
    chk("t1_mem_reqs", 32'(mv_cnt), 32'd1);
    tick();
    chk("t1_idle_ready", 32'(req_ready), 32'd1);

    // 2: byte loads, signed then unsigned
    mem_word = 32'h80112233;
    do_req(1'b0, 32'h80000003, 32'h0, 2'b00, 1'b1);
    wait_resp(cyc);
    chk("t2_sext_rdata", resp_rdata, 32'hFFFFFF80);
    tick();
    do_req(1'b0, 32'h80000003, 32'h0, 2'b00, 1'b0);
    wait_resp(cyc);
    chk("t2_zext_rdata", resp_rdata, 32'h00000080);
    tick();

    // 3: half store
    mv_cnt = 0;
    do_req(1'b1, 32'h80000002, 32'h0000ABCD, 2'b01, 1'b0);
    chk("t3_mem_valid", 32'(mem_valid), 32'd1);
    chk("t3_mem_wen", 32'(mem_wen), 32'd1);
    chk("t3_waddr", mem_waddr, 32'h80000000);
    chk("t3_wdata", mem_wdata, 32'hABCD0000);
    chk("t3_wmask", 32'(mem_wmask), 32'h0C);
    wait_resp(cyc);
    chk("t3_latency", 32'(cyc), 32'd2);
    chk("t3_mem_valid_off", 32'(mem_valid), 32'd0);
    chk("t3_rdata", resp_rdata, 32'd0);
    chk("t3_mem_reqs", 32'(mv_cnt), 32'd1);
    tick();

    // 4: misaligned / illegal size
    mv_cnt = 0;
    do_req(1'b0, 32'h80000001, 32'h0, 2'b10, 1'b0);
    chk("t4w_resp_valid", 32'(resp_valid), 32'd1);
    chk("t4w_err", 32'(resp_err), 32'd1);
    chk("t4w_rdata", resp_rdata, 32'd0);
    tick();
    do_req(1'b0, 32'h80000003, 32'h0, 2'b01, 1'b1);
    chk("t4h_resp_valid", 32'(resp_valid), 32'd1);
    chk("t4h_err", 32'(resp_err), 32'd1);
    tick();
    do_req(1'b0, 32'h80000000, 32'h0, 2'b11, 1'b0);
    chk("t4s_err", 32'(resp_err), 32'd1);
    chk("t4s_rdata", resp_rdata, 32'd0);
    tick();
    chk("t4_mem_reqs", 32'(mv_cnt), 32'd0);

    // 5: backpressure with an ignored second request
    mem_word = 32'h12345678;
    resp_ready = 1'b0;
    mv_cnt = 0;
    do_req(1'b0, 32'h80000008, 32'h0, 2'b10, 1'b0);
    wait_resp(cyc);
    chk("t5_latency", 32'(cyc), 32'd3);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80000010; req_size = 2'b10;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(resp_valid), 32'd1);
      chk("t5_hold_rdata", resp_rdata, 32'h12345678);
      chk("t5_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    chk("t5_still_valid", 32'(resp_valid), 32'd1);
    tick();
    chk("t5_done_valid", 32'(resp_valid), 32'd0);
    chk("t5_done_ready", 32'(req_ready), 32'd1);
    chk("t5_mem_reqs", 32'(mv_cnt), 32'd1);

    // 6: reset during WAIT on the MEM_LAT=3 instance, then a byte store
    rst3_n = 1'b1;
    tick();
    do_req(1'b0, 32'h80000004, 32'h0, 2'b10, 1'b0);
    chk("t6_mem_valid3", 32'(mem_valid3), 32'd1);
    tick(); tick();
    chk("t6_in_wait", 32'(req_ready3), 32'd0);
    mv3_cnt = 0;
    rst3_n = 1'b0;
    #1;
    chk("t6_rst_mem_valid", 32'(mem_valid3), 32'd0);
    chk("t6_rst_resp_valid", 32'(resp_valid3), 32'd0);
    chk("t6_rst_req_ready", 32'(req_ready3), 32'd1);
    tick();
    rst3_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_reissue", 32'(mv3_cnt), 32'd0);
    chk("t6_no_resp", 32'(resp_valid3), 32'd0);
    do_req(1'b1, 32'h80000001, 32'h0000005A, 2'b00, 1'b0);
    chk("t6_st_valid", 32'(mem_valid3), 32'd1);
    chk("t6_st_wmask", 32'(mem_wmask3), 32'h02);
    chk("t6_st_wdata", mem_wdata3, 32'h00005A00);
    chk("t6_st_waddr", mem_waddr3, 32'h80000000);
    tick();
    chk("t6_st_resp", 32'(resp_valid3), 32'd1);
    chk("t6_st_rdata", resp_rdata3, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Initiator side of the pmem request interface: the load/store unit that converts EXU load/store requests into word-aligned memory transactions.
- Drives valid, address, write data and 8-bit byte mask. Captures the registered read data returned by the memory model.
- Performs byte-lane extraction with sign/zero extension, and detects misaligned accesses.
- Sits between EXU (upstream, valid/ready) and the pmem DPI model (downstream, fixed read latency).

Parameters:
- MEM_LAT, 1, cycles from the edge that samples mem_valid until mem_rdata is captured (legal range 1..7)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EXU request valid
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_sext  in  1  sign-extend load result
- resp_valid  out  1  result valid
- resp_ready  in  1  WBU accepts result
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned or illegal-size access
- mem_valid  out  1  memory request (read or write)
- mem_raddr  out  32  word-aligned read address
- mem_rdata  in  32  memory read data (registered in memory)
- mem_wen  out  1  write enable, only with mem_valid
- mem_waddr  out  32  word-aligned write address (equal to mem_raddr)
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  8  byte enables; bits [7:4] always 0

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- req_ready = (state==IDLE). The handshake occurs when req_valid && req_ready on a rising edge; all req_* fields are latched at that edge.
- Offset off = addr[1:0].
- Error when any of:
  - size==11
  - size==01 and off[0]==1
  - size==10 and off!=0
- Transitions:
  - IDLE -> RESP on an erroring request. No memory access occurs; resp_err=1, resp_rdata=0.
  - IDLE -> REQ on a legal request.
- REQ lasts exactly one cycle:
  - mem_valid=1.
  - mem_raddr = mem_waddr = {addr[31:2],2'b00}.
  - mem_wen = latched wen.
  - Store: mem_wdata = wdata << (8*off); mem_wmask = {4'b0, base<<off}, where base is 0001 (byte), 0011 (half) or 1111 (word). REQ -> RESP.
  - Load: mem_wmask=0, mem_wdata=0. REQ -> WAIT.
- WAIT:
  - A counter counts MEM_LAT cycles.
  - On the edge ending the last WAIT cycle, mem_rdata is captured into the result register. WAIT -> RESP.
- Load extraction:
  - sh = mem_rdata >> (8*off).
  - byte: low 8 bits, extended by bit 7 if sext, else zero.
  - half: low 16 bits, extended by bit 15 if sext, else zero.
  - word: unchanged.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - RESP -> IDLE on resp_valid && resp_ready. A new request can be accepted one cycle later, not in the same cycle.
- Latency (request accepted at edge 0):
  - load: resp_valid from cycle 2+MEM_LAT
  - store: resp_valid from cycle 2
  - error: resp_valid from cycle 1
- Outside REQ: mem_valid=0, mem_wen=0, mem_wmask=0. Each transaction issues exactly one memory request.
- Reset:
  - All outputs are 0 except req_ready=1.
  - State goes to IDLE, counter to 0, result register to 0.
  - Reset asserted mid-transaction (any state) drops mem_valid/mem_wen immediately (asynchronously). The pending transaction is discarded and never reissued.
- req_valid while not in IDLE is ignored; no stall or change occurs.

Test Plan:
1. Reset then word load: addr 0x80000004, size 10, memory word 0xDEADBEEF, MEM_LAT=1 -> one cycle mem_valid with raddr 0x80000004; resp_valid in cycle 3; rdata 0xDEADBEEF; err 0.
2. Byte loads at addr 0x80000003, mem word 0x80112233:
   - sext=1 -> rdata 0xFFFFFF80
   - sext=0 -> rdata 0x00000080
3. Half store: addr 0x80000002, wdata 0x0000ABCD -> mem_valid=1, mem_wen=1, waddr 0x80000000, wdata 0xABCD0000, wmask 0x0C, for exactly one cycle; resp_valid in cycle 2, rdata 0.
4. Misaligned word load at 0x80000001, then half at 0x80000003 -> no mem_valid; resp_valid in cycle 1 with resp_err=1, rdata 0. Repeat for size 11 -> resp_err=1.
5. Backpressure: hold resp_ready=0 for 5 cycles after a load of 0x12345678 -> resp_valid and rdata stable throughout; req_ready=0; a second req_valid is ignored. After resp_ready=1, IDLE follows and req_ready=1 one cycle later.
6. Reset mid-operation: rst_n low during WAIT with MEM_LAT=3 -> mem_valid=0, resp_valid=0, req_ready=1 immediately; after release, a new byte store at 0x80000001 of 0x5A gives wmask 0x02, wdata 0x00005A00.
